// File: rtl/x_mux_pkg.sv
// Shared definitions for the frame-aligned N-to-1 output multiplexer.
package x_mux_pkg;

  // Frame alignment state
  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_RUN      = 1'b1
  } x_mux_state_e;

  // Fill bit for the default idle word (all-ones blanks the link)
  localparam logic IDLE_FILL = 1'b1;

  // Width of the saturating frame error counter
  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/x_mux_slice_reg.sv
// NSLICE x WIDTH frame holding register with a registered slice select.
// On a load cycle the incoming frame is bypassed so slice sel_i of the new
// frame appears on dout_o one cycle after the strobe.
module x_mux_slice_reg
  import x_mux_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     NSLICE   = 4,
  parameter logic [WIDTH-1:0] IDLE_VAL = {WIDTH{IDLE_FILL}},
  parameter int unsigned     PW       = $clog2(NSLICE)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load_i,
  input  logic [NSLICE*WIDTH-1:0]  din_i,
  input  logic [PW-1:0]            sel_i,
  input  logic                     drive_i,
  output logic [WIDTH-1:0]         dout_o
);

  logic [WIDTH-1:0] hold_q  [NSLICE];
  logic [WIDTH-1:0] din_arr [NSLICE];
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;

  // Split the flat frame bus into slices
  always_comb begin
    for (int k = 0; k < int'(NSLICE); k++) begin
      din_arr[k] = din_i[k*WIDTH +: WIDTH];
    end
  end

  // Next output word: selected slice, or idle when not driving
  always_comb begin
    dout_d = IDLE_VAL;
    if (drive_i) begin
      dout_d = load_i ? din_arr[sel_i] : hold_q[sel_i];
    end
  end

  // Holding register and output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(NSLICE); k++) begin
        hold_q[k] <= IDLE_VAL;
      end
      dout_q <= IDLE_VAL;
    end else begin
      if (load_i) begin
        for (int k = 0; k < int'(NSLICE); k++) begin
          hold_q[k] <= din_arr[k];
        end
      end
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/x_mux_frame_nto1.sv
// Frame-aligned N-to-1 time multiplexer: captures one frame per strobe and
// emits one slice per clock, tracking alignment and flagging bad strobes.
// Optional: define X_MUX_ERR_CNT_EN to implement the saturating err_cnt;
// otherwise err_cnt is tied to zero.
module x_mux_frame_nto1
  import x_mux_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      NSLICE   = 4,
  parameter logic [WIDTH-1:0] IDLE_VAL = {WIDTH{IDLE_FILL}}
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    frame_strobe,
  input  logic [NSLICE*WIDTH-1:0] din,
  input  logic                    din_valid,
  input  logic                    blank,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_first,
  output logic                    locked,
  output logic                    frame_err,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int unsigned   PW   = $clog2(NSLICE);
  localparam logic [PW-1:0] LAST = PW'(NSLICE - 1);

  x_mux_state_e             state_q, state_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic                     locked_q, locked_d;
  logic                     err_q, err_d;
  logic                     first_q, first_d;
  logic                     load;
  logic                     drive;
  logic [NSLICE*WIDTH-1:0]  din_eff;

  // An invalid frame is stored as all idle words
  assign din_eff = din_valid ? din : {NSLICE{IDLE_VAL}};

  // Alignment tracking: next state, phase, error and output qualifiers
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (frame_strobe) begin
          load     = 1'b1;
          phase_d  = '0;
          state_d  = ST_RUN;
          locked_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_strobe) begin
          load    = 1'b1;
          phase_d = '0;
          err_d   = (phase_q != LAST);
        end else if (phase_q == LAST) begin
          err_d    = 1'b1;
          phase_d  = '0;
          state_d  = ST_UNLOCKED;
          locked_d = 1'b0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d  = ST_UNLOCKED;
        phase_d  = '0;
        locked_d = 1'b0;
      end
    endcase
    first_d = (state_d == ST_RUN) && (phase_d == '0);
    drive   = (state_d == ST_RUN) && !blank;
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_UNLOCKED;
      phase_q  <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  x_mux_slice_reg #(
    .WIDTH    (WIDTH),
    .NSLICE   (NSLICE),
    .IDLE_VAL (IDLE_VAL),
    .PW       (PW)
  ) u_slice_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (load),
    .din_i   (din_eff),
    .sel_i   (phase_d),
    .drive_i (drive),
    .dout_o  (dout)
  );

`ifdef X_MUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of frame errors, cleared only by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign dout_first = first_q;
  assign locked     = locked_q;
  assign frame_err  = err_q;

endmodule
